game_round_controller: RTL and testbench

- Parametrised multi-round successor to the single-round game control FSM; sequences IDLE -> countdown -> play -> inter-round gap -> ... -> game over across NUM_ROUNDS rounds.
- Owns its countdown and play-time counters, driven by an external 1 Hz tick pulse.
- Adds pause/resume and cumulative total-score accumulation.
- Drives score counter, mole controller and 7-seg display path.

---
 rtl/game_round_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_game_round_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_controller.sv
// -----------------------------------------------------------------------------
// game_round_controller
//
// Multi-round game sequencer: IDLE -> COUNTDOWN -> PLAYING -> ROUND_END -> ...
// -> GAME_OVER over NUM_ROUNDS rounds, with pause/resume and a saturating
// total-score accumulator. Countdown, play and gap timers are owned here and
// advance on the external 1 Hz tick pulse.
//
// Inputs are all single-cycle pulses sampled on the rising edge of clk; there
// is no handshake. When several pulses coincide they are resolved in the order
// rst > btn_start > btn_pause > tick_1hz > btn_difficulty, and a pulse that
// loses is dropped.
//
// Optional feature (macro HIGH_SCORE_EN): adds high_score / new_high_pulse,
// a best-total register that survives btn_start and is cleared only by rst.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   tick_1hz           one-cycle pulse per second
//   btn_start          start / restart game (any state)
//   btn_pause          toggle PLAYING <-> PAUSED
//   btn_difficulty     advance difficulty (IDLE / GAME_OVER only)
//   score_in           current round score from the score counter
//   enable_score       score counter enable (PLAYING)
//   clear_score        score counter clear (IDLE, COUNTDOWN)
//   enable_mole_ctrl   mole controller enable (PLAYING)
//   difficulty_level   selected difficulty, 0..DIFF_LEVELS-1
//   state_out          current state code (debug / display)
//   round_num          current round, 1-based, 0 in IDLE
//   time_left          seconds left in the current timed state
//   time_bcd           time_left as {tens, ones} BCD
//   total_score        saturating sum of completed round scores
//   high_score         (HIGH_SCORE_EN) best total since reset
//   new_high_pulse     (HIGH_SCORE_EN) one cycle when high_score improves
//   game_over_pulse    one cycle on entry to GAME_OVER
// -----------------------------------------------------------------------------
module game_round_controller #(
    parameter int COUNTDOWN_SEC = 5,
    parameter int GAME_SEC      = 30,
    parameter int ROUND_GAP_SEC = 2,
    parameter int NUM_ROUNDS    = 3,
    parameter int DIFF_LEVELS   = 3,
    parameter int SCORE_W       = 8,
    parameter int TOTAL_W       = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               btn_difficulty,
    input  logic [SCORE_W-1:0] score_in,
    output logic               enable_score,
    output logic               clear_score,
    output logic               enable_mole_ctrl,
    output logic [1:0]         difficulty_level,
    output logic [2:0]         state_out,
    output logic [2:0]         round_num,
    output logic [6:0]         time_left,
    output logic [7:0]         time_bcd,
    output logic [TOTAL_W-1:0] total_score,
`ifdef HIGH_SCORE_EN
    output logic [TOTAL_W-1:0] high_score,
    output logic               new_high_pulse,
`endif
    output logic               game_over_pulse
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAYING   = 3'd2,
        S_PAUSED    = 3'd3,
        S_ROUND_END = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    // Sum is formed one bit wider than either operand so overflow is visible
    // before clamping to the all-ones total.
    localparam int SUM_W = ((TOTAL_W > SCORE_W) ? TOTAL_W : SCORE_W) + 1;
    localparam logic [SUM_W-1:0] TOTAL_MAX = SUM_W'({TOTAL_W{1'b1}});

    state_t               state_q, state_d;
    logic [2:0]           round_d;
    logic [6:0]           time_d;
    logic [TOTAL_W-1:0]   total_d;
    logic [1:0]           diff_d;
    logic                 go_d;
    logic [1:0]           diff_next;
    logic [SUM_W-1:0]     sum_wide;
    logic [TOTAL_W-1:0]   total_sat;
    logic [3:0]           bcd_tens, bcd_ones;

    assign state_out = state_q;

    assign diff_next = (difficulty_level == 2'(DIFF_LEVELS - 1)) ? 2'd0
                                                                  : difficulty_level + 2'd1;
    assign sum_wide  = SUM_W'(total_score) + SUM_W'(score_in);
    assign total_sat = (sum_wide > TOTAL_MAX) ? {TOTAL_W{1'b1}} : sum_wide[TOTAL_W-1:0];

    // BCD is derived from the next time value so it lands on the same edge
    // as time_left itself.
    assign bcd_tens = 4'(time_d / 7'd10);
    assign bcd_ones = 4'(time_d % 7'd10);

    always_comb begin
        state_d = state_q;
        round_d = round_num;
        time_d  = time_left;
        total_d = total_score;
        diff_d  = difficulty_level;
        go_d    = 1'b0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (btn_difficulty) diff_d = diff_next;
            end
            S_COUNTDOWN: begin
                if (tick_1hz) begin
                    if (time_left == 7'd1) begin
                        state_d = S_PLAYING;
                        time_d  = 7'(GAME_SEC);
                    end else begin
                        time_d  = time_left - 7'd1;
                    end
                end
            end
            S_PLAYING: begin
                // Pause outranks the tick, so a final tick coinciding with
                // pause leaves time_left at 1.
                if (btn_pause) begin
                    state_d = S_PAUSED;
                end else if (tick_1hz) begin
                    if (time_left == 7'd1) begin
                        total_d = total_sat;
                        if (round_num == 3'(NUM_ROUNDS)) begin
                            state_d = S_GAME_OVER;
                            time_d  = 7'd0;
                            go_d    = 1'b1;
                        end else begin
                            state_d = S_ROUND_END;
                            time_d  = 7'(ROUND_GAP_SEC);
                        end
                    end else begin
                        time_d = time_left - 7'd1;
                    end
                end
            end
            S_PAUSED: begin
                if (btn_pause) state_d = S_PLAYING;
            end
            S_ROUND_END: begin
                if (tick_1hz) begin
                    if (time_left == 7'd1) begin
                        state_d = S_COUNTDOWN;
                        round_d = round_num + 3'd1;
                        time_d  = 7'(COUNTDOWN_SEC);
                    end else begin
                        time_d  = time_left - 7'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = 3'd0;
                time_d  = 7'd0;
            end
        endcase

        // Start overrides everything evaluated above, including difficulty.
        if (btn_start) begin
            state_d = S_COUNTDOWN;
            round_d = 3'd1;
            time_d  = 7'(COUNTDOWN_SEC);
            total_d = '0;
            diff_d  = difficulty_level;
            go_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            round_num        <= 3'd0;
            time_left        <= 7'd0;
            time_bcd         <= 8'd0;
            total_score      <= '0;
            difficulty_level <= 2'd0;
            game_over_pulse  <= 1'b0;
            enable_score     <= 1'b0;
            enable_mole_ctrl <= 1'b0;
            clear_score      <= 1'b1;
        end else begin
            state_q          <= state_d;
            round_num        <= round_d;
            time_left        <= time_d;
            time_bcd         <= {bcd_tens, bcd_ones};
            total_score      <= total_d;
            difficulty_level <= diff_d;
            game_over_pulse  <= go_d;
            enable_score     <= (state_d == S_PLAYING);
            enable_mole_ctrl <= (state_d == S_PLAYING);
            clear_score      <= (state_d == S_IDLE) || (state_d == S_COUNTDOWN);
        end
    end

`ifdef HIGH_SCORE_EN
    // total_d is the final, already-saturated total on the GAME_OVER entry cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_score     <= '0;
            new_high_pulse <= 1'b0;
        end else begin
            new_high_pulse <= 1'b0;
            if (go_d && (total_d > high_score)) begin
                high_score     <= total_d;
                new_high_pulse <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_game_round_controller.sv
// -----------------------------------------------------------------------------
// tb_game_round_controller
//
// Two instances share all stimulus: dut_a with a 10-bit total and dut_b with a
// 5-bit total so saturation is exercised alongside normal accumulation.
// A behavioural model of the game rules predicts every output each cycle;
// a negedge process compares both instances against it. Directed sequences
// pin the model with hand-computed literals, then a random phase follows.
// -----------------------------------------------------------------------------
module tb_game_round_controller;

    localparam int CD  = 3;
    localparam int GS  = 5;
    localparam int GAP = 2;
    localparam int NR  = 2;
    localparam int DL  = 3;
    localparam int MAX_A = 1023;
    localparam int MAX_B = 31;

    // clock / reset / inputs
    logic       clk;
    logic       rst, tick_1hz, btn_start, btn_pause, btn_difficulty;
    logic [7:0] score_in;

    // dut_a outputs
    logic       en_a, clr_a, mole_a, go_a;
    logic [1:0] diff_a;
    logic [2:0] st_a, rnd_a;
    logic [6:0] tl_a;
    logic [7:0] bcd_a;
    logic [9:0] tot_a;
    // dut_b outputs
    logic       en_b, clr_b, mole_b, go_b;
    logic [1:0] diff_b;
    logic [2:0] st_b, rnd_b;
    logic [6:0] tl_b;
    logic [7:0] bcd_b;
    logic [4:0] tot_b;
`ifdef HIGH_SCORE_EN
    logic [9:0] hs_a;
    logic [4:0] hs_b;
    logic       nh_a, nh_b;
`endif

    game_round_controller #(
        .COUNTDOWN_SEC(CD), .GAME_SEC(GS), .ROUND_GAP_SEC(GAP), .NUM_ROUNDS(NR),
        .DIFF_LEVELS(DL), .SCORE_W(8), .TOTAL_W(10)
    ) dut_a (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_start(btn_start),
        .btn_pause(btn_pause), .btn_difficulty(btn_difficulty), .score_in(score_in),
        .enable_score(en_a), .clear_score(clr_a), .enable_mole_ctrl(mole_a),
        .difficulty_level(diff_a), .state_out(st_a), .round_num(rnd_a),
        .time_left(tl_a), .time_bcd(bcd_a), .total_score(tot_a),
`ifdef HIGH_SCORE_EN
        .high_score(hs_a), .new_high_pulse(nh_a),
`endif
        .game_over_pulse(go_a)
    );

    game_round_controller #(
        .COUNTDOWN_SEC(CD), .GAME_SEC(GS), .ROUND_GAP_SEC(GAP), .NUM_ROUNDS(NR),
        .DIFF_LEVELS(DL), .SCORE_W(8), .TOTAL_W(5)
    ) dut_b (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_start(btn_start),
        .btn_pause(btn_pause), .btn_difficulty(btn_difficulty), .score_in(score_in),
        .enable_score(en_b), .clear_score(clr_b), .enable_mole_ctrl(mole_b),
        .difficulty_level(diff_b), .state_out(st_b), .round_num(rnd_b),
        .time_left(tl_b), .time_bcd(bcd_b), .total_score(tot_b),
`ifdef HIGH_SCORE_EN
        .high_score(hs_b), .new_high_pulse(nh_b),
`endif
        .game_over_pulse(go_b)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard counters ----------------
    int total_n = 0;
    int bad_n   = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases use the published state codes: 0 idle, 1 countdown, 2 playing,
    // 3 paused, 4 round gap, 5 game over.
    int m_phase, m_round, m_time, m_tot_a, m_tot_b, m_diff, m_hs_a, m_hs_b;
    bit m_go, m_nh_a, m_nh_b;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step(input bit r, st, pa, tk, df, input int sc);
        m_go = 0; m_nh_a = 0; m_nh_b = 0;
        if (r) begin
            m_phase = 0; m_round = 0; m_time = 0; m_tot_a = 0; m_tot_b = 0;
            m_diff = 0; m_hs_a = 0; m_hs_b = 0;
        end else if (st) begin
            m_phase = 1; m_round = 1; m_time = CD; m_tot_a = 0; m_tot_b = 0;
        end else if (m_phase == 0 || m_phase == 5) begin
            if (df) m_diff = (m_diff + 1) % DL;
        end else if (m_phase == 3) begin
            if (pa) m_phase = 2;
        end else if (m_phase == 2 && pa) begin
            m_phase = 3;
        end else if (tk) begin
            if (m_time > 1) begin
                m_time = m_time - 1;
            end else if (m_phase == 1) begin
                m_phase = 2; m_time = GS;
            end else if (m_phase == 4) begin
                m_phase = 1; m_round = m_round + 1; m_time = CD;
            end else begin
                m_tot_a = sat(m_tot_a + sc, MAX_A);
                m_tot_b = sat(m_tot_b + sc, MAX_B);
                if (m_round == NR) begin
                    m_phase = 5; m_time = 0; m_go = 1;
                    if (m_tot_a > m_hs_a) begin m_hs_a = m_tot_a; m_nh_a = 1; end
                    if (m_tot_b > m_hs_b) begin m_hs_b = m_tot_b; m_nh_b = 1; end
                end else begin
                    m_phase = 4; m_time = GAP;
                end
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            int bcd_exp;
            bcd_exp = (m_time / 10) * 16 + (m_time % 10);
            check("a_state", st_a,  m_phase);   check("b_state", st_b,  m_phase);
            check("a_round", rnd_a, m_round);   check("b_round", rnd_b, m_round);
            check("a_time",  tl_a,  m_time);    check("b_time",  tl_b,  m_time);
            check("a_bcd",   bcd_a, bcd_exp);   check("b_bcd",   bcd_b, bcd_exp);
            check("a_total", tot_a, m_tot_a);   check("b_total", tot_b, m_tot_b);
            check("a_diff",  diff_a, m_diff);   check("b_diff",  diff_b, m_diff);
            check("a_en",    en_a,   m_phase == 2);  check("b_en",   en_b,   m_phase == 2);
            check("a_mole",  mole_a, m_phase == 2);  check("b_mole", mole_b, m_phase == 2);
            check("a_clr",   clr_a, m_phase <= 1);   check("b_clr",  clr_b,  m_phase <= 1);
            check("a_go",    go_a,  m_go);      check("b_go",    go_b,  m_go);
`ifdef HIGH_SCORE_EN
            check("a_hs", hs_a, m_hs_a);  check("b_hs", hs_b, m_hs_b);
            check("a_nh", nh_a, m_nh_a);  check("b_nh", nh_b, m_nh_b);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, st, pa, tk, df, input logic [7:0] sc);
        rst = r; btn_start = st; btn_pause = pa; tick_1hz = tk;
        btn_difficulty = df; score_in = sc;
        @(posedge clk);
        model_step(r, st, pa, tk, df, int'(sc));
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 8'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            drive(0, 0, 0, 1, 0, 8'd0);
        end
    endtask

    // Four plain ticks, then the final tick carrying the round score.
    task automatic play_round(input logic [7:0] sc);
        ticks(GS - 1);
        idle();
        drive(0, 0, 0, 1, 0, sc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; tick_1hz = 0; btn_start = 0; btn_pause = 0;
        btn_difficulty = 0; score_in = 8'd0;

        // reset
        drive(1, 0, 0, 0, 0, 8'd0);
        chk_en = 1'b1;
        drive(1, 0, 0, 0, 0, 8'd0);
        check("pin_rst_state", st_a, 0);
        check("pin_rst_clr", clr_a, 1);
        check("pin_rst_total", tot_a, 0);
        check("pin_rst_diff", diff_a, 0);
        idle();

        // game 1: countdown 3,2,1 then play
        drive(0, 1, 0, 0, 0, 8'd0);
        check("pin_cd_state", st_a, 1);
        check("pin_cd_t3", tl_a, 3);
        check("pin_cd_round", rnd_a, 1);
        ticks(1); check("pin_cd_t2", tl_a, 2);
        ticks(1); check("pin_cd_t1", tl_a, 1);
        ticks(1);
        check("pin_play_state", st_a, 2);
        check("pin_play_t5", tl_a, 5);
        check("pin_play_bcd", bcd_a, 8'h05);
        check("pin_play_mole", mole_a, 1);
        play_round(8'd12);
        check("pin_gap_state", st_a, 4);
        check("pin_gap_t2", tl_a, 2);
        check("pin_gap_total", tot_a, 12);
        ticks(1); check("pin_gap_t1", tl_a, 1);
        ticks(1);
        check("pin_r2_state", st_a, 1);
        check("pin_r2_round", rnd_a, 2);
        ticks(CD);
        play_round(8'd20);
        check("pin_go_state", st_a, 5);
        check("pin_go_pulse", go_a, 1);
        check("pin_go_total_a", tot_a, 32);
        check("pin_go_total_b", tot_b, 31);
        check("pin_go_round", rnd_a, 2);
`ifdef HIGH_SCORE_EN
        check("pin_hs_a", hs_a, 32);
        check("pin_hs_b", hs_b, 31);
        check("pin_nh_b", nh_b, 1);
`endif
        idle();
        check("pin_go_pulse_off", go_a, 0);
        check("pin_go_hold", tot_a, 32);

        // game 2: 20 + 20
        drive(0, 1, 0, 0, 0, 8'd0);
        check("pin_g2_clear_total", tot_a, 0);
        ticks(CD); play_round(8'd20); ticks(GAP); ticks(CD); play_round(8'd20);
        check("pin_g2_total_a", tot_a, 40);
        check("pin_g2_total_b", tot_b, 31);
`ifdef HIGH_SCORE_EN
        check("pin_g2_nh_a", nh_a, 1);
        check("pin_g2_nh_b", nh_b, 0);
        check("pin_g2_hs_b", hs_b, 31);
`endif
        idle();

        // pause / resume
        drive(0, 1, 0, 0, 0, 8'd0);
        ticks(CD); ticks(1);
        check("pin_pre_pause_t4", tl_a, 4);
        drive(0, 0, 1, 0, 0, 8'd0);
        check("pin_paused_state", st_a, 3);
        check("pin_paused_en", en_a, 0);
        check("pin_paused_mole", mole_a, 0);
        ticks(3);
        check("pin_paused_t4", tl_a, 4);
        drive(0, 0, 1, 0, 0, 8'd0);
        check("pin_resume_state", st_a, 2);
        ticks(1);
        check("pin_resume_t3", tl_a, 3);
        ticks(2);
        drive(0, 0, 1, 1, 0, 8'd0);
        check("pin_pause_final_state", st_a, 3);
        check("pin_pause_final_t1", tl_a, 1);
        drive(0, 0, 1, 0, 0, 8'd0);
        drive(0, 1, 0, 1, 0, 8'd0);
        check("pin_start_tick_t3", tl_a, 3);

        // difficulty
        drive(1, 0, 0, 0, 0, 8'd0);
        drive(0, 0, 0, 0, 1, 8'd0); check("pin_diff_1", diff_a, 1);
        drive(0, 0, 0, 0, 1, 8'd0); check("pin_diff_2", diff_a, 2);
        drive(0, 0, 0, 0, 1, 8'd0); check("pin_diff_0", diff_a, 0);
        drive(0, 0, 0, 0, 1, 8'd0); check("pin_diff_1b", diff_a, 1);
        drive(0, 1, 0, 0, 0, 8'd0);
        ticks(CD);
        drive(0, 0, 0, 0, 1, 8'd0);
        check("pin_diff_playing", diff_a, 1);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 799) == 0,
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0,
                  8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
